// File: rtl/sram_fb_reader_if.sv
// Async SRAM word-bus bundle: the fetcher drives address and enables,
// the memory side returns read data.
interface sram_fb_reader_if;
    logic [17:0] ram_addr;
    logic [15:0] ram_din;
    logic        ram_ce;
    logic        ram_oe;
    logic        ram_we;
    logic        ram_lb;
    logic        ram_hb;

    modport master (
        output ram_addr, ram_ce, ram_oe, ram_we, ram_lb, ram_hb,
        input  ram_din
    );

    modport slave (
        input  ram_addr, ram_ce, ram_oe, ram_we, ram_lb, ram_hb,
        output ram_din
    );
endinterface

// File: rtl/sram_fb_reader.sv
// Framebuffer scan-out fetcher: reads one frame of 12-bit RGB words from async
// SRAM (two clk100 cycles per word) into a small first-word-fall-through FIFO.
module sram_fb_reader #(
    parameter int FIFO_DEPTH = 16,
    parameter int H_WORDS    = 400,
    parameter int V_LINES    = 300
) (
    input  logic                    clk100,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic [17:0]             base_addr,
    sram_fb_reader_if.master        ram,
    input  logic                    pix_pop,
    output logic [11:0]             pix_data,
    output logic                    pix_valid,
    output logic                    underflow,
    output logic                    frame_done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // One extra counter bit so a frame of exactly 2^18 words can still terminate.
    localparam logic [18:0]      FRAME_WORDS = 19'(H_WORDS * V_LINES);
    localparam logic [CNT_W-1:0] DEPTH       = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, CAPTURE} state_t;

    state_t             state_q, state_d;
    logic               active_q, active_d;
    logic [17:0]        base_q, base_d;
    logic [18:0]        word_cnt_q, word_cnt_d;
    logic [17:0]        ram_addr_q, ram_addr_d;
    logic               en_q, en_d;
    logic               frame_done_q, frame_done_d;
    logic               underflow_q, underflow_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [11:0]        pix_data_q, pix_data_d;
    logic               pix_valid_q, pix_valid_d;
    logic [11:0]        mem_q [FIFO_DEPTH];
    logic               push, pop;
    logic               unused_din;

    assign unused_din = ^ram.ram_din[15:12];

    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        base_d       = base_q;
        word_cnt_d   = word_cnt_q;
        ram_addr_d   = ram_addr_q;
        en_d         = en_q;
        frame_done_d = frame_done_q;
        underflow_d  = underflow_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        pix_data_d   = pix_data_q;
        pix_valid_d  = pix_valid_q;
        push         = 1'b0;
        pop          = 1'b0;

        if (frame_start) begin
            state_d      = IDLE;
            active_d     = 1'b1;
            base_d       = base_addr;
            word_cnt_d   = '0;
            en_d         = 1'b0;
            frame_done_d = 1'b0;
            underflow_d  = 1'b0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            cnt_d        = '0;
            pix_data_d   = '0;
            pix_valid_d  = 1'b0;
        end else begin
            pop = pix_pop && pix_valid_q;
            if (pix_pop && !pix_valid_q) underflow_d = 1'b1;

            // The FIFO slot is reserved while a read is in flight, so the
            // refill test counts the word being captured as already stored.
            unique case (state_q)
                IDLE: begin
                    if (active_q && (word_cnt_q < FRAME_WORDS) && (cnt_q < DEPTH)) begin
                        state_d    = ADDR;
                        ram_addr_d = base_q + word_cnt_q[17:0];
                        en_d       = 1'b1;
                    end
                end
                ADDR: state_d = CAPTURE;
                CAPTURE: begin
                    push       = 1'b1;
                    word_cnt_d = word_cnt_q + 19'd1;
                    if (word_cnt_d == FRAME_WORDS) frame_done_d = 1'b1;
                    if ((word_cnt_d < FRAME_WORDS) && ((cnt_q + CNT_W'(1)) < DEPTH)) begin
                        state_d    = ADDR;
                        ram_addr_d = base_q + word_cnt_d[17:0];
                    end else begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase

            rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d    = wr_ptr_q + PTR_W'(push);
            cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);
            pix_valid_d = (cnt_d != '0);
            // The new head may be the word being written on this same edge.
            if (cnt_d == '0)
                pix_data_d = '0;
            else if (push && (rd_ptr_d == wr_ptr_q))
                pix_data_d = ram.ram_din[11:0];
            else
                pix_data_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            active_q     <= 1'b0;
            base_q       <= '0;
            word_cnt_q   <= '0;
            ram_addr_q   <= '0;
            en_q         <= 1'b0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            base_q       <= base_d;
            word_cnt_q   <= word_cnt_d;
            ram_addr_q   <= ram_addr_d;
            en_q         <= en_d;
            frame_done_q <= frame_done_d;
            underflow_q  <= underflow_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
        end
    end

    always_ff @(posedge clk100) begin
        if (push) mem_q[wr_ptr_q] <= ram.ram_din[11:0];
    end

    assign ram.ram_addr = ram_addr_q;
    assign ram.ram_ce   = en_q;
    assign ram.ram_oe   = en_q;
    assign ram.ram_lb   = en_q;
    assign ram.ram_hb   = en_q;
    assign ram.ram_we   = 1'b0;
    assign pix_data     = pix_data_q;
    assign pix_valid    = pix_valid_q;
    assign underflow    = underflow_q;
    assign frame_done   = frame_done_q;
endmodule

// File: tb/tb_sram_fb_reader.sv
// Directed bench for sram_fb_reader: a full-size instance (A) and a 4x2 frame
// instance (B) share stimulus; a scoreboard queue holds expected pixels.
module tb_sram_fb_reader;
    logic        clk100 = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [17:0] base_addr;
    logic        pix_pop;

    logic [11:0] pix_data_a, pix_data_b;
    logic        pix_valid_a, pix_valid_b;
    logic        underflow_a, underflow_b;
    logic        frame_done_a, frame_done_b;

    sram_fb_reader_if ram_a ();
    sram_fb_reader_if ram_b ();

    // SRAM model: upper nibble is junk the reader must drop.
    assign ram_a.ram_din = {4'hA, ram_a.ram_addr[11:0]};
    assign ram_b.ram_din = {4'h5, ram_b.ram_addr[11:0]};

    int          vectors    = 0;
    int          miscompares = 0;
    logic [11:0] q_a [$];
    logic [11:0] q_b [$];

    always #5 clk100 = ~clk100;

    sram_fb_reader dut_a (
        .clk100      (clk100),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .base_addr   (base_addr),
        .ram         (ram_a),
        .pix_pop     (pix_pop),
        .pix_data    (pix_data_a),
        .pix_valid   (pix_valid_a),
        .underflow   (underflow_a),
        .frame_done  (frame_done_a)
    );

    sram_fb_reader #(.H_WORDS(4), .V_LINES(2)) dut_b (
        .clk100      (clk100),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .base_addr   (base_addr),
        .ram         (ram_b),
        .pix_pop     (pix_pop),
        .pix_data    (pix_data_b),
        .pix_valid   (pix_valid_b),
        .underflow   (underflow_b),
        .frame_done  (frame_done_b)
    );

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [17:0] base, input logic pop);
        frame_start = 1'b1;
        base_addr   = base;
        pix_pop     = pop;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic drain_a(input int budget);
        pix_pop = 1'b1;
        for (int c = 0; c < budget && q_a.size() != 0; c++) begin
            if (pix_valid_a) chk("a_fifo_order", pix_data_a, q_a.pop_front());
            tick();
        end
        pix_pop = 1'b0;
        chk("a_fifo_drained", q_a.size(), 0);
    endtask

    logic [17:0] wexp [4];
    int          extra_b;

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        base_addr   = '0;
        pix_pop     = 1'b0;
        repeat (2) tick();
        chk("rst_addr",      ram_a.ram_addr, 0);
        chk("rst_ce",        ram_a.ram_ce,   0);
        chk("rst_oe",        ram_a.ram_oe,   0);
        chk("rst_we",        ram_a.ram_we,   0);
        chk("rst_lb_hb",     {ram_a.ram_lb, ram_a.ram_hb}, 0);
        chk("rst_pix_data",  pix_data_a,     0);
        chk("rst_pix_valid", pix_valid_a,    0);
        chk("rst_underflow", underflow_a,    0);
        chk("rst_frame_done", frame_done_a,  0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_ce_oe",  {ram_a.ram_ce, ram_a.ram_oe}, 0);
            chk("idle_valid",  pix_valid_a, 0);
            chk("idle_addr",   ram_a.ram_addr, 0);
        end

        // Pop on an empty FIFO latches underflow until the next frame_start.
        pix_pop = 1'b1;
        tick();
        pix_pop = 1'b0;
        chk("underflow_set",  underflow_a, 1);
        chk("underflow_no_valid", pix_valid_a, 0);
        repeat (3) tick();
        chk("underflow_sticky", underflow_a, 1);

        pulse(18'h00100, 1'b1);
        pix_pop = 1'b0;
        chk("fs_clears_underflow", underflow_a, 0);
        chk("fs_pop_ignored_valid", pix_valid_a, 0);

        for (int k = 1; k <= 32; k++) begin
            tick();
            chk("fill_addr", ram_a.ram_addr, 18'h00100 + 18'((k - 1) / 2));
            chk("fill_ce_oe_lb_hb", {ram_a.ram_ce, ram_a.ram_oe, ram_a.ram_lb, ram_a.ram_hb}, 4'hF);
            if (k == 3) begin
                chk("first_pix_valid", pix_valid_a, 1);
                chk("first_pix_data",  pix_data_a,  12'h100);
            end
        end
        tick();
        chk("full_stop_ce", ram_a.ram_ce, 0);
        repeat (4) tick();
        chk("full_hold_ce",   ram_a.ram_ce,   0);
        chk("full_hold_addr", ram_a.ram_addr, 18'h0010F);
        chk("full_head",      pix_data_a,     12'h100);
        chk("full_we",        ram_a.ram_we,   0);

        // One pop frees one slot; the next edge starts a new read.
        pix_pop = 1'b1;
        tick();
        pix_pop = 1'b0;
        chk("pop_new_head", pix_data_a, 12'h101);
        tick();
        chk("refill_ce",   ram_a.ram_ce,   1);
        chk("refill_addr", ram_a.ram_addr, 18'h00110);
        for (int i = 1; i <= 24; i++) q_a.push_back(12'(12'h100 + i));
        drain_a(120);

        // Small frame on B with continuous popping.
        for (int i = 0; i < 8; i++) q_b.push_back(12'(12'h100 + i));
        pulse(18'h00100, 1'b1);
        chk("b_frame_done_cleared", frame_done_b, 0);
        extra_b = 0;
        for (int c = 0; c < 60; c++) begin
            if (pix_valid_b) begin
                if (q_b.size() != 0) chk("b_pixel", pix_data_b, q_b.pop_front());
                else extra_b++;
            end
            tick();
        end
        pix_pop = 1'b0;
        chk("b_all_popped",  q_b.size(),  0);
        chk("b_no_extra",    extra_b,     0);
        chk("b_frame_done",  frame_done_b, 1);
        chk("b_enables_low", {ram_b.ram_ce, ram_b.ram_oe, ram_b.ram_lb, ram_b.ram_hb}, 0);
        chk("b_empty",       pix_valid_b, 0);

        // Address wrap past the top of the 18-bit space.
        wexp[0] = 18'h3FFFE; wexp[1] = 18'h3FFFF; wexp[2] = 18'h00000; wexp[3] = 18'h00001;
        pulse(18'h3FFFE, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k % 2 == 1) chk("wrap_addr", ram_a.ram_addr, wexp[k / 2]);
        end
        q_a.push_back(12'hFFE); q_a.push_back(12'hFFF);
        q_a.push_back(12'h000); q_a.push_back(12'h001);
        drain_a(40);

        // Abort a read in CAPTURE with five entries queued.
        pulse(18'h00200, 1'b0);
        repeat (12) tick();
        chk("abort_pre_ce",    ram_a.ram_ce, 1);
        chk("abort_pre_head",  pix_data_a,   12'h200);
        pulse(18'h00300, 1'b0);
        chk("abort_flush_valid", pix_valid_a, 0);
        chk("abort_flush_data",  pix_data_a,  0);
        chk("abort_ce_low",      ram_a.ram_ce, 0);
        tick();
        chk("abort_new_addr", ram_a.ram_addr, 18'h00300);
        chk("abort_new_ce",   ram_a.ram_ce,   1);
        tick();
        tick();
        chk("abort_new_valid", pix_valid_a, 1);
        chk("abort_new_head",  pix_data_a,  12'h300);
        for (int i = 0; i < 4; i++) q_a.push_back(12'(12'h300 + i));
        drain_a(40);

        // Asynchronous reset in the middle of a read.
        for (int c = 0; c < 4 && !ram_a.ram_ce; c++) tick();
        chk("pre_reset_ce", ram_a.ram_ce, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ce",    {ram_a.ram_ce, ram_a.ram_oe}, 0);
        chk("async_rst_addr",  ram_a.ram_addr, 0);
        chk("async_rst_valid", pix_valid_a, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle_ce", ram_a.ram_ce, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
